// File: rtl/plb_master_arbiter.sv
// Round-robin arbiter sharing one PLB IPIF single-beat master port between
// NUM_REQ requesters. Holds the grant from pick to completion, registers the
// command onto the bus, routes responses to the owner and aborts hung
// transactions after WATCHDOG_CYCLES.
module plb_master_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned C_MST_AWIDTH    = 32,
  parameter int unsigned C_MST_DWIDTH    = 32,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic                              PLB_clk,
  input  logic                              reset_n,
  input  logic [0:NUM_REQ-1]                req_rd,
  input  logic [0:NUM_REQ-1]                req_wr,
  input  logic [0:NUM_REQ*C_MST_AWIDTH-1]   req_addr,
  input  logic [0:NUM_REQ*C_MST_DWIDTH-1]   req_wdata,
  input  logic [0:NUM_REQ*C_MST_DWIDTH/8-1] req_be,
  output logic [0:NUM_REQ-1]                req_grant,
  output logic [0:NUM_REQ-1]                req_cmdack,
  output logic [0:NUM_REQ-1]                req_cmplt,
  output logic [0:NUM_REQ-1]                req_error,
  output logic [0:C_MST_DWIDTH-1]           req_rdata,
  output logic [0:NUM_REQ-1]                req_rd_src_rdy_n,
  output logic                              IP2Bus_MstRd_Req,
  output logic                              IP2Bus_MstWr_Req,
  output logic [0:C_MST_AWIDTH-1]           IP2Bus_Mst_Addr,
  output logic [0:C_MST_DWIDTH/8-1]         IP2Bus_Mst_BE,
  output logic [0:C_MST_DWIDTH-1]           IP2Bus_MstWr_d,
  output logic                              IP2Bus_Mst_Lock,
  output logic                              IP2Bus_Mst_Reset,
  input  logic                              Bus2IP_Mst_CmdAck,
  input  logic                              Bus2IP_Mst_Cmplt,
  input  logic                              Bus2IP_Mst_Error,
  input  logic                              Bus2IP_Mst_Rearbitrate,
  input  logic                              Bus2IP_Mst_Cmd_Timeout,
  input  logic [0:C_MST_DWIDTH-1]           Bus2IP_MstRd_d,
  input  logic                              Bus2IP_MstRd_src_rdy_n,
  input  logic                              Bus2IP_MstWr_dst_rdy_n
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(WATCHDOG_CYCLES) + 1;
  localparam int unsigned BW = C_MST_DWIDTH / 8;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StAbort = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [IW-1:0]           last_q, last_d;
  logic                    req_on_q, req_on_d;
  logic                    is_rd_q, is_rd_d;
  logic [0:C_MST_AWIDTH-1] addr_q, addr_d;
  logic [0:BW-1]           be_q, be_d;
  logic [0:C_MST_DWIDTH-1] wdata_q, wdata_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [0:NUM_REQ-1]      eligible;
  logic                    pick_vld;
  logic [IW-1:0]           pick_idx;
  logic [IW-1:0]           cand;
  logic                    ack_ok, cmplt_ok, abort, wd_expired;

  logic [0:C_MST_AWIDTH-1] addr_arr  [NUM_REQ];
  logic [0:C_MST_DWIDTH-1] wdata_arr [NUM_REQ];
  logic [0:BW-1]           be_arr    [NUM_REQ];

  // Single-beat commands hold write data stable, so dst_rdy needs no handling.
  logic unused_dst_rdy;
  assign unused_dst_rdy = Bus2IP_MstWr_dst_rdy_n;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*C_MST_AWIDTH +: C_MST_AWIDTH];
    assign wdata_arr[g] = req_wdata[g*C_MST_DWIDTH +: C_MST_DWIDTH];
    assign be_arr[g]    = req_be[g*BW +: BW];
  end

  assign eligible   = req_rd | req_wr;
  assign ack_ok     = (state_q == StIssue) & req_on_q & Bus2IP_Mst_CmdAck;
  // Cmplt in ISSUE only counts when it arrives together with the ack.
  assign cmplt_ok   = Bus2IP_Mst_Cmplt & ((state_q == StWait) | ack_ok);
  assign abort      = (state_q == StAbort);
  assign wd_expired = (cnt_q >= CW'(WATCHDOG_CYCLES - 1));

  // Round-robin pick: first eligible requester after the last owner.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((32'(last_q) + k) % NUM_REQ);
      if (!pick_vld && eligible[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state: arbitration, command latch, rearbitrate retry and watchdog.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    req_on_d = req_on_q;
    is_rd_d  = is_rd_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d  = StIssue;
          owner_d  = pick_idx;
          req_on_d = 1'b1;
          is_rd_d  = req_rd[pick_idx];
          addr_d   = addr_arr[pick_idx];
          be_d     = be_arr[pick_idx];
          wdata_d  = wdata_arr[pick_idx];
          cnt_d    = '0;
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 1'b1;
        if (cmplt_ok) begin
          state_d  = StIdle;
          last_d   = owner_q;
          req_on_d = 1'b0;
        end else if (wd_expired) begin
          state_d  = StAbort;
          req_on_d = 1'b0;
        end else if (ack_ok) begin
          state_d  = StWait;
          req_on_d = 1'b0;
        end else begin
          // Rearbitrate drops the request for exactly one cycle.
          req_on_d = !(req_on_q && Bus2IP_Mst_Rearbitrate);
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (Bus2IP_Mst_Cmplt) begin
          state_d = StIdle;
          last_d  = owner_q;
        end else if (wd_expired) begin
          state_d = StAbort;
        end
      end
      default: begin
        state_d  = StIdle;
        last_d   = owner_q;
        req_on_d = 1'b0;
      end
    endcase
  end

  // State and command registers.
  always_ff @(posedge PLB_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      last_q   <= IW'(NUM_REQ - 1);
      req_on_q <= 1'b0;
      is_rd_q  <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      req_on_q <= req_on_d;
      is_rd_q  <= is_rd_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Route responses to the current owner only.
  always_comb begin
    req_grant        = '0;
    req_cmdack       = '0;
    req_cmplt        = '0;
    req_error        = '0;
    req_rd_src_rdy_n = '1;
    if (state_q != StIdle) begin
      req_grant[owner_q]        = 1'b1;
      req_cmdack[owner_q]       = ack_ok;
      req_cmplt[owner_q]        = cmplt_ok | abort;
      req_error[owner_q]        = (cmplt_ok & (Bus2IP_Mst_Error | Bus2IP_Mst_Cmd_Timeout)) | abort;
      req_rd_src_rdy_n[owner_q] = Bus2IP_MstRd_src_rdy_n;
    end
  end

  assign req_rdata        = Bus2IP_MstRd_d;
  assign IP2Bus_MstRd_Req = req_on_q & is_rd_q;
  assign IP2Bus_MstWr_Req = req_on_q & ~is_rd_q;
  assign IP2Bus_Mst_Addr  = addr_q;
  assign IP2Bus_Mst_BE    = be_q;
  assign IP2Bus_MstWr_d   = wdata_q;
  assign IP2Bus_Mst_Lock  = 1'b0;
  assign IP2Bus_Mst_Reset = abort;

endmodule
